fb_scan_arbiter: RTL

- Shares one single-port pixel RAM (RGB444 words) between display scan-out and a single pixel writer (drawing engine or CPU).
- Prefetches scan-out pixels into a small show-ahead FIFO that the VGA pixel path pops once per visible pixel.
- Display refill has priority; the writer gets all remaining RAM cycles.
- Sits between the VGA timing generator and the framebuffer RAM.

---
 rtl/fb_scan_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fb_scan_arbiter.sv
// fb_scan_arbiter: shares a single-port RGB444 framebuffer RAM between display
// scan-out (prefetched into a show-ahead FIFO) and one pixel writer.
// Display refill has priority below the low-water mark; the writer gets the rest.
// Ports:
//   clk, reset (async, active-low)
//   frame_start         one-cycle pulse before the first visible pixel
//   pix_pop             consume the FIFO head
//   pix_data/pix_empty  FIFO head (holds last value while empty) / empty flag
//   underflow           sticky: pop while empty, cleared by frame_start
//   wr_valid/wr_ready   writer handshake (wr_ready combinational)
//   wr_addr/wr_data     writer address / pixel
//   mem_en/mem_we/mem_addr/mem_wdata  registered RAM command
//   mem_rdata           RAM read data, valid the cycle after a read command
module fb_scan_arbiter #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned FB_DEPTH   = 76800,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LOW_WATER  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_empty,
    output logic              underflow,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [LVL_W-1:0]  level, level_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] head_nxt;
    // rd_v1: read command on the RAM port; rd_v2: its data on mem_rdata
    logic              rd_v1, rd_v2;
    logic [1:0]        inflight;
    logic              room, last_rd, wr_in_range;
    logic              rd_gnt, wr_gnt, ready_c;
    logic              push, pop;

    // Grant bookkeeping
    always_comb begin
        inflight    = {1'b0, rd_v1} + {1'b0, rd_v2};
        room        = (level + LVL_W'(inflight)) < LVL_W'(FIFO_DEPTH);
        last_rd     = (rd_addr == ADDR_W'(FB_DEPTH - 1));
        wr_in_range = (wr_addr < ADDR_W'(FB_DEPTH));
        push        = rd_v2 & ~frame_start;
        pop         = pix_pop & (level != '0) & ~frame_start;
        level_nxt   = frame_start ? '0 : (level + LVL_W'(push) - LVL_W'(pop));
        rd_ptr_nxt  = rd_ptr + PTR_W'(pop);
    end

    // Next state and grant selection
    always_comb begin
        state_nxt = state;
        rd_gnt    = 1'b0;
        wr_gnt    = 1'b0;
        ready_c   = 1'b0;
        if (frame_start) begin
            state_nxt = ST_FILL;
        end else begin
            case (state)
                ST_FILL: begin
                    if (room) rd_gnt = 1'b1;
                    else      state_nxt = ST_SERVE;
                end
                ST_SERVE: begin
                    ready_c = 1'b1;
                    if (wr_valid)  wr_gnt = 1'b1;
                    else if (room) rd_gnt = 1'b1;
                    if (level <= LVL_W'(LOW_WATER)) state_nxt = ST_FILL;
                end
                ST_DONE: begin
                    ready_c = 1'b1;
                    if (wr_valid) wr_gnt = 1'b1;
                end
                default: state_nxt = ST_DONE;
            endcase
            // The final read of the frame always parks the arbiter
            if (rd_gnt && last_rd) state_nxt = ST_DONE;
        end
    end

    // Held low during reset so the handshake is idle immediately
    assign wr_ready = ready_c & reset;

    // Next FIFO head: a push into a FIFO that is empty after this pop becomes the head
    always_comb begin
        head_nxt = pix_data;
        if (level_nxt != '0) begin
            if ((level - LVL_W'(pop)) == '0) head_nxt = mem_rdata;
            else                             head_nxt = fifo_mem[rd_ptr_nxt];
        end
    end

    // State, RAM command, in-flight tracking and FIFO control
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_DONE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_addr   <= '0;
            rd_v1     <= 1'b0;
            rd_v2     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            pix_data  <= '0;
            pix_empty <= 1'b1;
            underflow <= 1'b0;
        end else begin
            state <= state_nxt;

            if (rd_gnt) begin
                mem_en   <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= rd_addr;
            end else if (wr_gnt && wr_in_range) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else begin
                mem_en <= 1'b0;
            end

            // frame_start discards any read whose data has not yet landed
            rd_v1 <= rd_gnt;
            rd_v2 <= rd_v1 & ~frame_start;

            if (frame_start)  rd_addr <= '0;
            else if (rd_gnt)  rd_addr <= last_rd ? '0 : rd_addr + 1'b1;

            if (frame_start) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                rd_ptr <= rd_ptr_nxt;
            end
            level     <= level_nxt;
            pix_data  <= head_nxt;
            pix_empty <= (level_nxt == '0);

            if (frame_start)                      underflow <= 1'b0;
            else if (pix_pop && (level == '0))    underflow <= 1'b1;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_rdata;
    end

endmodule
